// File: rtl/timer_pkg.sv
// Shared types and mode-bit encodings for the interval timer controller.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam logic DIR_UP        = 1'b1;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/prescaler_parameter.sv
// Prescaler: emits a tick every prescale+1 enabled cycles; count freezes while en is low.
module prescaler_parameter #(
  parameter int pre_width = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic [pre_width-1:0] prescale,
  output logic                 tick
);

  logic [pre_width-1:0] cnt;

  assign tick = en && (cnt == prescale);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/interval_timer_controller.sv
// Interval timer controller: start/pause/resume/abort FSM driving a prescaled
// up/down counter with terminal-count pulse and sticky interrupt.
module interval_timer_controller
  import timer_pkg::*;
#(
  parameter int width     = 16,
  parameter int pre_width = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 clear,
  input  logic                 up,
  input  logic                 periodic,
  input  logic [width-1:0]     load_value,
  input  logic [pre_width-1:0] prescale,
  input  logic                 irq_ack,
  output logic [width-1:0]     q,
  output logic                 busy,
  output logic                 tick,
  output logic                 tc,
  output logic                 irq
);

  timer_state_t state, state_nxt;

  logic                 up_s, per_s;
  logic [width-1:0]     load_s;
  logic [pre_width-1:0] pre_s;
  logic [width-1:0]     q_nxt, term, origin;
  logic                 tc_nxt, launch, run_en, pre_clr;

  // A fresh start only launches from IDLE/DONE; stop outranks start everywhere.
  assign launch  = start && !stop && !clear && (state == IDLE || state == DONE);
  assign run_en  = (state == RUN) && !stop && !clear;
  assign pre_clr = clear || launch;

  assign term   = (up_s == DIR_UP) ? load_s : '0;
  assign origin = (up_s == DIR_UP) ? '0 : load_s;
  assign busy   = (state == RUN) || (state == PAUSE);

  prescaler_parameter #(
    .pre_width(pre_width)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (run_en),
    .clr      (pre_clr),
    .prescale (pre_s),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    tc_nxt    = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
      q_nxt     = '0;
    end else if (launch) begin
      state_nxt = RUN;
      q_nxt     = (up == DIR_UP) ? '0 : load_value;
    end else begin
      case (state)
        RUN: begin
          if (stop) begin
            state_nxt = PAUSE;
          end else if (tick) begin
            if (q == term) begin
              tc_nxt = 1'b1;
              if (per_s == MODE_PERIODIC) begin
                q_nxt = origin;
              end else begin
                state_nxt = DONE;
              end
            end else begin
              q_nxt = (up_s == DIR_UP) ? q + 1'b1 : q - 1'b1;
            end
          end
        end
        PAUSE: begin
          if (start && !stop) begin
            state_nxt = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  // irq is set from the registered tc, so an ack during the tc cycle loses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q      <= '0;
      tc     <= 1'b0;
      irq    <= 1'b0;
      up_s   <= 1'b0;
      per_s  <= 1'b0;
      load_s <= '0;
      pre_s  <= '0;
    end else begin
      q   <= q_nxt;
      tc  <= tc_nxt;
      irq <= tc || (irq && !irq_ack);
      if (launch) begin
        up_s   <= up;
        per_s  <= periodic;
        load_s <= load_value;
        pre_s  <= prescale;
      end
    end
  end

endmodule

// File: doc/interval_timer_controller.md
Name: interval_timer_controller

Overview:
- Programmable interval timer controller: sequences a loadable up/down counter through a prescaler, with start/pause/resume/abort control.
- Generates a terminal-count pulse and a sticky interrupt, in one-shot or periodic mode.
- Sits between a register/bus front end and the counter datapath; provides timebases and event timing for the rest of the design.

Parameters:
width, 16, counter width (q, load_value)
pre_width, 8, prescaler width (prescale)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (reset == 0 clears all state immediately)
start  input  1  start from IDLE/DONE (loads config); resume from PAUSE
stop  input  1  pause while RUN
clear  input  1  abort to IDLE from any state
up  input  1  count direction, sampled at start: 1 = up, 0 = down
periodic  input  1  mode, sampled at start: 1 = periodic reload, 0 = one-shot
load_value  input  width  terminal value (up) or start value (down), sampled at start
prescale  input  pre_width  tick every prescale+1 cycles, sampled at start
irq_ack  input  1  clears irq
q  output  width  current count
busy  output  1  state is RUN or PAUSE
tick  output  1  one-cycle pulse on each prescaler tick (RUN only)
tc  output  1  one-cycle registered terminal-count pulse
irq  output  1  sticky interrupt, set by tc

Behaviour:
- Reset (reset == 0): state = IDLE, q = 0, prescaler count = 0, shadow registers = 0, tc = 0, irq = 0. busy = 0, tick = 0.
- States: IDLE, RUN, PAUSE, DONE.
- Priority each cycle: clear > stop > start.
- IDLE or DONE with start = 1:
  - latch up, periodic, load_value, prescale into shadow regs.
  - q <= (up ? 0 : load_value); prescaler count <= 0; next state RUN.
- Start value S = (up ? 0 : load_value). Terminal T = (up ? load_value : 0).
- RUN, prescaler:
  - prescaler count increments every cycle.
  - tick = 1 (combinational from registered count) when count == prescale_shadow; count then <= 0.
  - prescale = 0 gives tick every RUN cycle.
- RUN, on tick:
  - q != T: q steps +1 (up) or -1 (down). No wrap is possible, since T bounds the count.
  - q == T: tc <= 1 for one cycle.
    - periodic: q <= S, stay in RUN.
    - one-shot: q holds T, next state DONE.
  - Resulting tc latency: first tc comes load_value+1 ticks after entering RUN. Periodic period is (load_value+1)*(prescale+1) cycles.
- load_value = 0: tc on the first tick. Periodic then fires tc on every tick.
- RUN with start = 1: ignored; no reload.
- RUN with stop = 1: next state PAUSE. q and prescaler count freeze; no tick that cycle.
- PAUSE with start = 1: next state RUN, resuming from the frozen q and count with no reload.
- PAUSE with stop = 1: remains PAUSE.
- clear in any state: next state IDLE, q <= 0, prescaler count <= 0, tc <= 0. irq is unaffected.
- DONE: q holds T, busy = 0. start restarts with fresh sampled inputs.
- irq: set when tc is set. Cleared by irq_ack. Simultaneous set and ack: set wins.
- Inputs are sampled only at start. Changing load_value/prescale/up/periodic mid-run has no effect.
- Reset asserted mid-operation aborts immediately to the reset values above.

Decomposition:
- Package timer_pkg:
  - typedef enum logic [1:0] timer_state_t {IDLE, RUN, PAUSE, DONE}.
  - localparam encodings for the up and periodic mode bits.
- Sub-module prescaler_parameter #(pre_width): inputs clk, reset, en, clr, prescale; output tick. Same reset polarity as the parent.
- Controller FSM, shadow registers, counter and irq logic live in interval_timer_controller.

Test Plan:
- Up one-shot, width = 16: load_value = 3, prescale = 0, start for 1 cycle -> q = 0,1,2,3 on successive cycles; tc high the cycle after q reaches 3; state DONE; q holds 3; irq = 1; busy = 0.
- Down periodic: load_value = 2, prescale = 1 -> tick every 2 cycles; q = 2,1,0,2,1,0; tc every 6 cycles; irq stays 1 until irq_ack; ack on the same cycle as tc leaves irq = 1.
- Pause/resume: up, load_value = 10, prescale = 0; stop when q = 4, hold stop for 5 cycles -> q stays 4, tick = 0; start -> q continues 5, 6, ...
- Priority: clear and stop asserted together while RUN at q = 7 -> IDLE, q = 0, busy = 0; irq unchanged. start during RUN with a new load_value = 1 -> ignored; terminal stays the original.
- Boundary: load_value = 0 periodic, prescale = 0 -> tc high every RUN cycle, q = 0. load_value = 16'hFFFF up -> tc after 65536 ticks, with no wrap before it.
- Reset: drive reset = 0 asynchronously mid-RUN (between edges) -> q = 0, tc = 0, irq = 0, busy = 0 immediately; after release, IDLE until start.
